// File: rtl/video_frame_normalizer.sv
// Vertical window normaliser: measures active lines per frame and, once the count is stable,
// re-centres a fixed TARGET_LINES window, padding window lines without source picture to black.
module video_frame_normalizer #(
  parameter int TARGET_LINES  = 240,
  parameter int MIN_LINES     = 64,
  parameter int STABLE_FRAMES = 4,
  parameter int LCNT_W        = 9
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pix_ce,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              pix_ce_o,
  output logic              hblank_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              vblank_o,
  output logic [7:0]        red_o,
  output logic [7:0]        green_o,
  output logic [7:0]        blue_o,
  output logic              locked,
  output logic [LCNT_W-1:0] lines_meas
);

  localparam int                LMAX    = (1 << LCNT_W) - 1;
  localparam int                SW      = LCNT_W + 2;
  localparam logic [LCNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]        STAB    = 4'(STABLE_FRAMES);

  function automatic logic [LCNT_W-1:0] sat_inc(input logic [LCNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Centre the target window on the measured region; clamp at line 0 rather than wrapping.
  function automatic logic [LCNT_W-1:0] calc_win_start(input logic [LCNT_W-1:0] c,
                                                       input logic [LCNT_W-1:0] f);
    logic signed [SW-1:0] cs, fs, ts, ws;
    cs = {2'b00, c};
    fs = {2'b00, f};
    ts = SW'(TARGET_LINES);
    if (cs >= ts) ws = fs + ((cs - ts) >>> 1);
    else          ws = fs - ((ts - cs) >>> 1);
    if (ws < 0)                 return '0;
    else if (ws > SW'(LMAX))    return CNT_MAX;
    else                        return ws[LCNT_W-1:0];
  endfunction

  function automatic logic [LCNT_W-1:0] calc_win_end(input logic [LCNT_W-1:0] ws);
    int s;
    s = int'(ws) + TARGET_LINES;
    if (s > LMAX) return CNT_MAX;
    return LCNT_W'(s);
  endfunction

  logic              hs_q, vs_q, hb_q;
  logic              hs_rise_p0, vs_rise_p0, hb_fall_p0;
  logic [LCNT_W-1:0] lcnt, act_cnt, first_l, cand, cand_first, win_start, win_end;
  logic              first_seen, skip_frame;
  logic [3:0]        stable_cnt;

  logic              meas_ok;
  logic [3:0]        stable_nx;
  logic [LCNT_W-1:0] cand_nx, cfirst_nx, ws_nx, we_nx;
  logic              win_blank_p0, norm_p0;

  assign hs_rise_p0 = pix_ce & hsync  & ~hs_q;
  assign vs_rise_p0 = pix_ce & vsync  & ~vs_q;
  assign hb_fall_p0 = pix_ce & ~hblank & hb_q;

  always_comb begin
    meas_ok   = int'(act_cnt) >= MIN_LINES;
    stable_nx = stable_cnt;
    cand_nx   = cand;
    cfirst_nx = cand_first;
    if (meas_ok) begin
      if (act_cnt == cand) begin
        stable_nx = (stable_cnt >= STAB) ? STAB : stable_cnt + 4'd1;
      end else begin
        cand_nx   = act_cnt;
        cfirst_nx = first_l;
        stable_nx = 4'd1;
      end
    end
  end

  assign ws_nx = calc_win_start(cand_nx, cfirst_nx);
  assign we_nx = calc_win_end(ws_nx);

  // ---- measurement and lock state ----
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hb_q       <= 1'b0;
      lcnt       <= '0;
      act_cnt    <= '0;
      first_l    <= '0;
      first_seen <= 1'b0;
      cand       <= '0;
      cand_first <= '0;
      stable_cnt <= '0;
      skip_frame <= 1'b0;
      locked     <= 1'b0;
      lines_meas <= '0;
      win_start  <= '0;
      win_end    <= '0;
    end else begin
      if (pix_ce) begin
        hs_q <= hsync;
        vs_q <= vsync;
        hb_q <= hblank;
      end
      if (vs_rise_p0)      lcnt <= '0;
      else if (hs_rise_p0) lcnt <= sat_inc(lcnt);

      if (vs_rise_p0) begin
        act_cnt    <= '0;
        first_seen <= 1'b0;
        skip_frame <= 1'b0;
        if (!skip_frame && enable) begin
          cand       <= cand_nx;
          cand_first <= cfirst_nx;
          stable_cnt <= stable_nx;
          if (meas_ok && stable_nx == STAB) begin
            locked     <= 1'b1;
            lines_meas <= cand_nx;
            win_start  <= ws_nx;
            win_end    <= we_nx;
          end
        end
      end else if (hb_fall_p0 && !vblank && !skip_frame) begin
        act_cnt <= sat_inc(act_cnt);
        if (!first_seen) begin
          first_l    <= lcnt;
          first_seen <= 1'b1;
        end
      end

      // A disabled block forgets its lock and ignores the frame in progress.
      if (!enable) begin
        locked     <= 1'b0;
        stable_cnt <= '0;
        skip_frame <= 1'b1;
      end
    end
  end

  assign norm_p0      = enable & locked;
  assign win_blank_p0 = (lcnt < win_start) | (lcnt >= win_end);

  // ---- output register stage (1 clk latency) ----
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pix_ce_o <= 1'b0;
      hblank_o <= 1'b0;
      hsync_o  <= 1'b0;
      vsync_o  <= 1'b0;
      vblank_o <= 1'b0;
      red_o    <= '0;
      green_o  <= '0;
      blue_o   <= '0;
    end else begin
      pix_ce_o <= pix_ce;
      hblank_o <= hblank;
      hsync_o  <= hsync;
      vsync_o  <= vsync;
      if (norm_p0) begin
        vblank_o <= win_blank_p0;
        if (vblank || win_blank_p0) begin
          red_o   <= '0;
          green_o <= '0;
          blue_o  <= '0;
        end else begin
          red_o   <= red;
          green_o <= green;
          blue_o  <= blue;
        end
      end else begin
        vblank_o <= vblank;
        red_o    <= red;
        green_o  <= green;
        blue_o   <= blue;
      end
    end
  end

endmodule

// File: tb/tb_video_frame_normalizer.sv
// Bench for video_frame_normalizer: random colours and pixel-strobe gaps over synthetic frames,
// compared every cycle against a frame-level reference model, plus directed window checks.
module tb_video_frame_normalizer;

  localparam int T    = 240;
  localparam int MINL = 64;
  localparam int STAB = 4;
  localparam int LMAX = 511;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       pix_ce  = 1'b0;
  logic       hblank  = 1'b0;
  logic       vblank  = 1'b0;
  logic       hsync   = 1'b0;
  logic       vsync   = 1'b0;
  logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;

  logic       pix_ce_o, hblank_o, hsync_o, vsync_o, vblank_o, locked;
  logic [7:0] red_o, green_o, blue_o;
  logic [8:0] lines_meas;

  logic       pix_ce_o8, hblank_o8, hsync_o8, vsync_o8, vblank_o8, locked8;
  logic [7:0] red_o8, green_o8, blue_o8;
  logic [7:0] lines_meas8;

  video_frame_normalizer #(.TARGET_LINES(T), .MIN_LINES(MINL), .STABLE_FRAMES(STAB), .LCNT_W(9)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .pix_ce(pix_ce),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_ce_o(pix_ce_o), .hblank_o(hblank_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .vblank_o(vblank_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .locked(locked), .lines_meas(lines_meas)
  );

  video_frame_normalizer #(.TARGET_LINES(T), .MIN_LINES(MINL), .STABLE_FRAMES(STAB), .LCNT_W(8)) dut8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .pix_ce(pix_ce),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_ce_o(pix_ce_o8), .hblank_o(hblank_o8), .hsync_o(hsync_o8), .vsync_o(vsync_o8),
    .vblank_o(vblank_o8), .red_o(red_o8), .green_o(green_o8), .blue_o(blue_o8),
    .locked(locked8), .lines_meas(lines_meas8)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  // Reference model state, tracked in frame/line terms
  int m_line, m_act, m_first, m_cand, m_cfirst, m_stable, m_ws, m_we, m_meas;
  bit m_first_seen, m_locked, m_skip;

  // Per-frame observations taken mid-line
  int obs_low, obs_first_low, obs_low8, obs_pad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_act = 0; m_first = 0; m_cand = 0; m_cfirst = 0; m_stable = 0;
    m_ws = 0; m_we = 0; m_meas = 0; m_first_seen = 0; m_locked = 0; m_skip = 0;
  endtask

  task automatic model_frame_end();
    if (!m_skip && enable) begin
      if (m_act >= MINL) begin
        if (m_act == m_cand) m_stable = (m_stable + 1 > STAB) ? STAB : m_stable + 1;
        else begin
          m_cand = m_act; m_cfirst = m_first; m_stable = 1;
        end
        if (m_stable == STAB) begin
          m_locked = 1;
          m_meas   = m_cand;
          if (m_cand >= T) m_ws = m_cfirst + (m_cand - T) / 2;
          else             m_ws = m_cfirst - (T - m_cand) / 2;
          if (m_ws < 0) m_ws = 0;
          m_we = (m_ws + T > LMAX) ? LMAX : m_ws + T;
        end
      end
    end
    m_skip = 0; m_act = 0; m_first_seen = 0;
  endtask

  task automatic cyc(input logic pce, input logic hs, input logic vs, input logic hb, input logic vb,
                     input bit evf, input bit evl, input bit eva);
    logic [23:0] rgb, rgbx;
    logic        norm, vbx;
    rgb = 24'($urandom);
    pix_ce = pce; hsync = hs; vsync = vs; hblank = hb; vblank = vb;
    {red, green, blue} = rgb;
    norm = enable && m_locked;
    vbx  = norm ? (m_line < m_ws || m_line >= m_we) : vb;
    rgbx = (norm && (vb || vbx)) ? 24'd0 : rgb;
    @(posedge clk_sys);
    if (pce) begin
      if (evf) begin
        model_frame_end();
        m_line = 0;
      end else if (evl && m_line < LMAX) m_line++;
      if (eva && !m_skip) begin
        if (m_act < LMAX) m_act++;
        if (!m_first_seen) begin
          m_first = m_line; m_first_seen = 1;
        end
      end
    end
    if (!enable) begin
      m_locked = 0; m_stable = 0; m_skip = 1;
    end
    #1;
    check("cycle", 64'({pix_ce_o, hblank_o, hsync_o, vsync_o, vblank_o, red_o, green_o, blue_o,
                        locked, lines_meas}),
          64'({pce, hb, hs, vs, vbx, rgbx, m_locked, 9'(m_meas)}));
  endtask

  task automatic slot(input logic hs, input logic vs, input logic hb, input logic vb,
                      input bit evf, input bit evl, input bit eva);
    if ($urandom_range(15) == 0) cyc(1'b0, hs, vs, hb, vb, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, hs, vs, hb, vb, evf, evl, eva);
  endtask

  task automatic line(input int k, input int a, input int c);
    logic vs, vb;
    vs = (k < 2);
    vb = !(k >= a && k < a + c);
    slot(1'b1, vs, 1'b1, vb, k == 0, k != 0, 1'b0);
    slot(1'b0, vs, 1'b1, vb, 1'b0, 1'b0, 1'b0);
    slot(1'b0, vs, 1'b0, vb, 1'b0, 1'b0, !vb);
    slot(1'b0, vs, 1'b0, vb, 1'b0, 1'b0, 1'b0);
    if (!vblank_o) begin
      obs_low++;
      if (obs_first_low < 0) obs_first_low = k;
      if (vb && {red_o, green_o, blue_o} == 24'd0) obs_pad++;
    end
    if (!vblank_o8) obs_low8++;
    slot(1'b0, vs, 1'b0, vb, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int n, input int a, input int c, input int chg, input logic en_new);
    obs_low = 0; obs_first_low = -1; obs_low8 = 0; obs_pad = 0;
    for (int k = 0; k < n; k++) begin
      if (k == chg) enable = en_new;
      line(k, a, c);
      if (k == chg && !en_new) begin
        check("en_drop_locked", 64'(locked), 64'(0));
        check("en_drop_vblank", 64'(vblank_o), 64'(vblank));
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      pix_ce = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
      hblank = 1'($urandom); vblank = 1'($urandom);
      {red, green, blue} = 24'($urandom);
      @(posedge clk_sys);
      #1;
      check("reset_out", 64'({pix_ce_o, hblank_o, hsync_o, vsync_o, vblank_o, red_o, green_o,
                              blue_o, locked, lines_meas}), 64'(0));
      check("reset_out8", 64'({vblank_o8, locked8, lines_meas8, red_o8}), 64'(0));
    end
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset(6);
    enable = 1'b1;
    repeat (8) cyc(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);

    // 242 active lines from line 20
    for (int f = 0; f < 4; f++) frame(262, 20, 242, -1, 1'b1);
    check("t2_unlocked_pre", 64'(locked), 64'(0));
    frame(262, 20, 242, -1, 1'b1);
    check("t2_locked", 64'(locked), 64'(1));
    check("t2_lines_meas", 64'(lines_meas), 64'(242));
    check("t2_win_first", 64'(obs_first_low), 64'(21));
    check("t2_win_count", 64'(obs_low), 64'(240));
    frame(262, 20, 242, -1, 1'b1);

    // Source shrinks to 200 lines at line 40
    for (int f = 0; f < 4; f++) begin
      frame(262, 40, 200, -1, 1'b1);
      check("t3_still_locked", 64'(locked), 64'(1));
      check("t3_old_window", 64'(obs_first_low), 64'(21));
    end
    check("t3_old_meas", 64'(lines_meas), 64'(242));
    frame(262, 40, 200, -1, 1'b1);
    check("t3_lines_meas", 64'(lines_meas), 64'(200));
    check("t3_win_first", 64'(obs_first_low), 64'(20));
    check("t3_win_count", 64'(obs_low), 64'(240));
    check("t3_pad_black", 64'(obs_pad), 64'(40));

    // Too-short active regions never lock
    do_reset(3);
    for (int f = 0; f < 8; f++) begin
      frame(120, 5, 10, -1, 1'b1);
      check("t4_no_lock", 64'(locked), 64'(0));
    end
    check("t4_no_meas", 64'(lines_meas), 64'(0));
    for (int f = 0; f < 4; f++) frame(262, 2, 100, -1, 1'b1);
    check("t4_unlocked_pre", 64'(locked), 64'(0));
    frame(262, 2, 100, -1, 1'b1);
    check("t4_locked", 64'(locked), 64'(1));
    check("t4_lines_meas", 64'(lines_meas), 64'(100));
    check("t4_clamp_first", 64'(obs_first_low), 64'(0));
    check("t4_win_count", 64'(obs_low), 64'(240));

    // Tall frames: 8-bit instance must saturate rather than wrap
    for (int f = 0; f < 5; f++) frame(300, 10, 290, -1, 1'b1);
    check("t5_lines_meas", 64'(lines_meas), 64'(290));
    check("t5_win_first", 64'(obs_first_low), 64'(35));
    check("t5_win_count", 64'(obs_low), 64'(240));
    check("t5_locked8", 64'(locked8), 64'(1));
    check("t5_lines_meas8", 64'(lines_meas8), 64'(255));
    check("t5_win_count8", 64'(obs_low8), 64'(238));

    // Enable dropped mid-frame, then re-enabled mid-frame
    frame(262, 20, 242, 100, 1'b0);
    frame(262, 20, 242, 50, 1'b1);
    check("t6_unlocked_skip", 64'(locked), 64'(0));
    for (int f = 0; f < 4; f++) frame(262, 20, 242, -1, 1'b1);
    check("t6_unlocked_pre", 64'(locked), 64'(0));
    frame(262, 20, 242, -1, 1'b1);
    check("t6_relocked", 64'(locked), 64'(1));
    check("t6_lines_meas", 64'(lines_meas), 64'(242));
    check("t6_win_first", 64'(obs_first_low), 64'(21));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
